// File: rtl/sw_ctrl_pkg.sv
// Stopwatch control shared definitions: FSM state encoding and
// default timing constants (1 Hz tick and 20 ms debounce at 100 MHz).
package sw_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int TICK_DIV_DEF  = 100_000_000;
    localparam int DB_CYCLES_DEF = 2_000_000;

endpackage

// File: rtl/sw_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce counter, press pulse.
// Ports: clk, rst (async, active-high), btn_raw (async in),
//        level (debounced level), press (1-cycle pulse on rising level).
module btn_debounce
    import sw_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CMAX) begin
                // level has differed for DB_CYCLES samples: accept it
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_ctrl.sv
// sw_ctrl: stopwatch front-end (debounce, IDLE/RUN/PAUSE FSM, tick prescaler).
// Ports: clk, rst (async, active-high), btn_start, btn_clr (raw buttons),
//        en (count tick), Clear (clear strobe), run (state == RUN).
// Option SW_CTRL_LAP_EN adds btn_lap (raw) and lap_hold (display freeze).
module sw_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_clr,
`ifdef SW_CTRL_LAP_EN
    input  logic btn_lap,
    output logic lap_hold,
`endif
    output logic en,
    output logic Clear,
    output logic run
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    sw_state_t     state;
    logic [PW-1:0] presc;
    logic          start_p;
    logic          clr_p;
    logic          unused_start_lvl;
    logic          unused_clr_lvl;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_start),
        .level   (unused_start_lvl),
        .press   (start_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clr),
        .level   (unused_clr_lvl),
        .press   (clr_p)
    );

    // Prescaler advances on every edge sampled in RUN, including the
    // edge that leaves RUN, and holds in PAUSE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            presc <= '0;
            en    <= 1'b0;
            Clear <= 1'b0;
            run   <= 1'b0;
        end else begin
            en    <= (state == ST_RUN) && (presc == PMAX);
            Clear <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    presc <= '0;
                    if (clr_p) begin
                        Clear <= 1'b1;
                    end else if (start_p) begin
                        state <= ST_RUN;
                        run   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    presc <= (presc == PMAX) ? '0 : presc + PW'(1);
                    if (start_p) begin
                        state <= ST_PAUSE;
                        run   <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (clr_p) begin
                        state <= ST_IDLE;
                        presc <= '0;
                        Clear <= 1'b1;
                    end else if (start_p) begin
                        state <= ST_RUN;
                        run   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    presc <= '0;
                    run   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SW_CTRL_LAP_EN
    logic lap_p;
    logic unused_lap_lvl;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_lap),
        .level   (unused_lap_lvl),
        .press   (lap_p)
    );

    // Cleared in IDLE and on the PAUSE->IDLE clear; toggles otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_hold <= 1'b0;
        end else if (state == ST_IDLE) begin
            lap_hold <= 1'b0;
        end else if (state == ST_PAUSE && clr_p) begin
            lap_hold <= 1'b0;
        end else if (lap_p) begin
            lap_hold <= ~lap_hold;
        end
    end
`endif

endmodule

// File: tb/tb_sw_ctrl.sv
// Directed self-checking bench for sw_ctrl (TICK_DIV=10, DB_CYCLES=4).
// Define SW_CTRL_LAP_EN to include the lap button checks.
module tb_sw_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_start;
    logic btn_clr;
    logic en;
    logic Clear;
    logic run;
`ifdef SW_CTRL_LAP_EN
    logic btn_lap;
    logic lap_hold;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ne, nc, tr, tf, te, tel, tc;
    bit ok;

    always #5 clk = ~clk;

    sw_ctrl #(.TICK_DIV(10), .DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
`ifdef SW_CTRL_LAP_EN
        .btn_lap   (btn_lap),
        .lap_hold  (lap_hold),
`endif
        .en        (en),
        .Clear     (Clear),
        .run       (run)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        btn_start = 1'b0;
        btn_clr   = 1'b0;
`ifdef SW_CTRL_LAP_EN
        btn_lap   = 1'b0;
`endif
    endtask

    // m: bit0 start, bit1 clr, bit2 lap. Buttons drop after tick 'hold'.
    task automatic run_win(input logic [2:0] m, input int hold,
                           input int len, output int n_en,
                           output int n_clr, output int t_rise,
                           output int t_fall, output int t_en,
                           output int t_en_last, output int t_clr);
        logic prev;
        n_en = 0; n_clr = 0;
        t_rise = -1; t_fall = -1;
        t_en = -1; t_en_last = -1; t_clr = -1;
        prev = run;
        if (m[0]) btn_start = 1'b1;
        if (m[1]) btn_clr = 1'b1;
`ifdef SW_CTRL_LAP_EN
        if (m[2]) btn_lap = 1'b1;
`endif
        for (int k = 1; k <= len; k++) begin
            tick();
            if (en) begin
                n_en++;
                if (t_en < 0) t_en = k;
                t_en_last = k;
            end
            if (Clear) begin
                n_clr++;
                if (t_clr < 0) t_clr = k;
            end
            if (run && !prev && t_rise < 0) t_rise = k;
            if (!run && prev && t_fall < 0) t_fall = k;
            prev = run;
            if (k == hold) release_all();
        end
    endtask

    task automatic wait_en(output bit found);
        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            tick();
            if (en) found = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        release_all();
        tick();
        tick();
        chk("rst_en", en, 0);
        chk("rst_clear", Clear, 0);
        chk("rst_run", run, 0);
        rst = 1'b0;

        // short glitch, then a long hold
        run_win(3'b001, 3, 12, ne, nc, tr, tf, te, tel, tc);
        chk("glitch_rise", tr, -1);
        chk("glitch_run", run, 0);
        run_win(3'b001, 20, 28, ne, nc, tr, tf, te, tel, tc);
        chk("hold_rise", tr, 7);
        chk("hold_run", run, 1);
        chk("hold_en_n", ne, 2);
        chk("hold_en_t", te, 17);

        // tick cadence
        wait_en(ok);
        chk("sync_en", ok, 1);
        run_win(3'b000, 0, 35, ne, nc, tr, tf, te, tel, tc);
        chk("cad_n", ne, 3);
        chk("cad_first", te, 10);
        chk("cad_last", tel, 30);

        // pause at prescaler 6, resume
        wait_en(ok);
        chk("sync_en2", ok, 1);
        run_win(3'b001, 10, 20, ne, nc, tr, tf, te, tel, tc);
        chk("pause_fall", tf, 7);
        chk("pause_en", ne, 0);
        run_win(3'b000, 0, 10, ne, nc, tr, tf, te, tel, tc);
        chk("pause_hold_en", ne, 0);
        chk("pause_run", run, 0);
        run_win(3'b001, 10, 20, ne, nc, tr, tf, te, tel, tc);
        chk("resume_rise", tr, 7);
        chk("resume_en", te, 10);

        // clr in RUN ignored
        run_win(3'b010, 8, 16, ne, nc, tr, tf, te, tel, tc);
        chk("runclr_n", nc, 0);
        chk("runclr_run", run, 1);
        // pause, then start+clr together
        run_win(3'b001, 8, 16, ne, nc, tr, tf, te, tel, tc);
        chk("p2_fall", tf, 7);
        run_win(3'b011, 8, 16, ne, nc, tr, tf, te, tel, tc);
        chk("both_clr_n", nc, 1);
        chk("both_clr_t", tc, 7);
        chk("both_rise", tr, -1);
        chk("both_run", run, 0);
        chk("both_en", ne, 0);
        // clr in IDLE
        run_win(3'b010, 8, 16, ne, nc, tr, tf, te, tel, tc);
        chk("idleclr_n", nc, 1);
        chk("idleclr_run", run, 0);
        // prescaler restarted from 0
        run_win(3'b001, 8, 20, ne, nc, tr, tf, te, tel, tc);
        chk("restart_rise", tr, 7);
        chk("restart_en", te, 17);

        // reset mid-run
        wait_en(ok);
        chk("sync_en3", ok, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_en", en, 0);
        chk("mrst_run", run, 0);
        chk("mrst_clear", Clear, 0);
        #3;
        rst = 1'b0;
        run_win(3'b000, 0, 15, ne, nc, tr, tf, te, tel, tc);
        chk("mrst_idle_en", ne, 0);
        chk("mrst_idle_run", run, 0);
        chk("mrst_idle_clr", nc, 0);
        run_win(3'b001, 8, 20, ne, nc, tr, tf, te, tel, tc);
        chk("mrst_start", tr, 7);

`ifdef SW_CTRL_LAP_EN
        chk("lap_init", lap_hold, 0);
        run_win(3'b100, 10, 20, ne, nc, tr, tf, te, tel, tc);
        chk("lap1_hold", lap_hold, 1);
        chk("lap1_en", ne, 2);
        run_win(3'b100, 10, 20, ne, nc, tr, tf, te, tel, tc);
        chk("lap2_hold", lap_hold, 0);
        run_win(3'b100, 10, 20, ne, nc, tr, tf, te, tel, tc);
        chk("lap3_hold", lap_hold, 1);
        run_win(3'b001, 10, 20, ne, nc, tr, tf, te, tel, tc);
        chk("lap_pause_run", run, 0);
        chk("lap_pause_hold", lap_hold, 1);
        run_win(3'b010, 10, 20, ne, nc, tr, tf, te, tel, tc);
        chk("lap_clr_n", nc, 1);
        chk("lap_clr_hold", lap_hold, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
